// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } det_state_e;

  localparam int MAX_W = 32;

  // Low `width` bits set; used for the compare-everything mask after reset.
  function automatic logic [MAX_W-1:0] mask_all_ones(input int width);
    if (width >= MAX_W) return '1;
    return (MAX_W'(1) << width) - MAX_W'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear is applied before increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] count_n;

  always_comb begin
    base    = clr ? '0 : count;
    count_n = base;
    if (inc && (base != '1)) count_n = base + 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
      sat   <= 1'b0;
    end else begin
      count <= count_n;
      sat   <= (count_n == '1);
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with per-bit don't-care mask, selectable overlap
// and a saturating match counter. Dout is a same-cycle (Mealy) match pulse.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Din,
  input  logic             In_valid,
  input  logic             Load,
  input  logic [PAT_W-1:0] Pattern,
  input  logic [PAT_W-1:0] Mask,
  input  logic             Overlap,
  input  logic             Clear_count,
  output logic             Dout,
  output logic [CNT_W-1:0] Match_count,
  output logic             Count_sat,
  output det_state_e       Dbg_state
);

  // Handshake: Din is consumed on every cycle In_valid is high and Load is low;
  // there is no ready/backpressure, so the upstream may never stall this block.

  localparam int HW = PAT_W - 1;
  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0]    FILL_LAST = FW'(HW);
  localparam logic [MAX_W-1:0] MASK_INIT = mask_all_ones(PAT_W);

  det_state_e       state, state_n;
  logic [PAT_W-1:0] pat_q, mask_q;
  logic [HW-1:0]    history, hist_n;
  logic [FW-1:0]    fill, fill_n;
  logic [PAT_W-1:0] window;
  logic             cmp_ok;
  logic             match;

  assign window    = {history, Din};
  assign cmp_ok    = (((window ^ pat_q) & mask_q) == '0);
  assign Dbg_state = state;

  always_comb begin
    state_n = state;
    hist_n  = history;
    fill_n  = fill;
    match   = 1'b0;
    if (Load) begin
      hist_n  = '0;
      fill_n  = '0;
      state_n = FILL;
    end else if (In_valid) begin
      hist_n = window[HW-1:0];
      if (state == FILL) begin
        fill_n = fill + 1'b1;
        if (fill_n == FILL_LAST) state_n = ARMED;
      end else begin
        match = cmp_ok;
        // Non-overlapping: the matched bits may not seed the next match.
        if (match && !Overlap) begin
          hist_n  = '0;
          fill_n  = '0;
          state_n = FILL;
        end
      end
    end
  end

  assign Dout = match & ~Reset;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= FILL;
      history <= '0;
      fill    <= '0;
      pat_q   <= '0;
      mask_q  <= MASK_INIT[PAT_W-1:0];
    end else begin
      state   <= state_n;
      history <= hist_n;
      fill    <= fill_n;
      if (Load) begin
        pat_q  <= Pattern;
        mask_q <= Mask;
      end
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_count (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (match),
    .clr   (Clear_count),
    .count (Match_count),
    .sat   (Count_sat)
  );

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
Parametrised serial bit-pattern detector. This is the successor of the team's fixed 3-state Mealy sequence FSM. It matches a runtime-loadable PAT_W-bit pattern with a per-bit don't-care mask against a qualified serial stream on Din. Selectable overlapping or non-overlapping detection. Mealy match pulse plus a saturating match counter. Sits between the serial front end and status/interrupt logic.

Parameters:
PAT_W  3  pattern length in bits (>= 2)
CNT_W  8  match counter width (>= 1)

Ports:
Clock        in   1      single clock, rising edge
Reset        in   1      asynchronous, active-high reset
Din          in   1      serial data bit
In_valid     in   1      Din qualifier; bit consumed only when high
Load         in   1      latch Pattern/Mask, restart detection
Pattern      in   PAT_W  pattern; bit PAT_W-1 is the oldest (first-received) bit
Mask         in   PAT_W  1 = compare bit, 0 = don't care
Overlap      in   1      1 = overlapping mode, 0 = non-overlapping mode; sampled per cycle
Clear_count  in   1      synchronous clear of Match_count/Count_sat
Dout         out  1      Mealy match indication
Match_count  out  CNT_W  saturating number of matches
Count_sat    out  1      high once Match_count reaches all-ones

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (Clock, Reset).
- Reset state:
  - pat_q = 0, mask_q = all-ones.
  - history (PAT_W-1 bits) = 0, fill = 0, FSM = FILL.
  - Match_count = 0, Count_sat = 0.
  - Dout forced 0 while Reset is high.
- Window: window = {history, Din}, PAT_W bits, Din in the LSB position.
- FSM states:
  - FILL: fewer than PAT_W-1 valid bits are held.
  - ARMED: history is full.
- Consume (In_valid=1, Load=0):
  - history shifts left and Din enters the LSB.
  - In FILL, fill increments. When fill reaches PAT_W-1, next state is ARMED.
- Match: match = ARMED & In_valid & ~Load & (((window ^ pat_q) & mask_q) == 0).
- Dout = match. It is combinational from Din/In_valid (Mealy), zero latency in the same cycle.
- On a match:
  - Overlap=1: history shifts as normal; state stays ARMED.
  - Overlap=0: history clears, fill = 0, state returns to FILL. A further PAT_W fresh bits are needed before the next match.
- Load=1 (priority over consume):
  - pat_q <= Pattern, mask_q <= Mask.
  - history, fill and state are cleared to FILL.
  - Din is ignored, Dout = 0, Match_count is unchanged.
- In_valid=0: no state change, Dout = 0.
- Counter:
  - Match_count increments by 1 on each match.
  - It saturates at 2^CNT_W-1, with no wrap.
  - Count_sat = (Match_count == all-ones), registered together with the count.
  - Clear_count=1 zeroes the count. If Clear_count and a match coincide, the result is count = 1 (clear then increment).
- mask_q = 0: every ARMED valid bit matches (documented behaviour, not an error).
- Reset asserted mid-stream: all state clears immediately. The stream restarts from FILL after Reset deasserts.

Decomposition:
- Package seq_det_pkg: FSM state encoding (FILL=1'b0, ARMED=1'b1) and the MASK_ALL_ONES helper constant/function.
- One sub-module, sat_counter (width CNT_W, inc, clr, count, sat). It is reusable elsewhere.
- Shift/compare logic and the FSM stay in the top module.

Test Plan:
- Load pattern 101, mask 111, Overlap=1; stream 1,0,1,0,1 -> Dout=1 on bits 3 and 5; Match_count=2.
- Same load with Overlap=0; stream 1,0,1,0,1 -> Dout=1 on bit 3 only; Match_count=1; stream 0,1 more -> second match on bit 7.
- Pattern 101, mask 101 (middle bit don't-care); stream 1,1,1 -> match on bit 3; stream 0,0,1 -> no match.
- In_valid gaps: 1,(gap),0,(gap x3),1 with pattern 101 -> single match on the last valid bit; Dout=0 in every gap cycle.
- CNT_W=2, Overlap=1, pattern 111, stream of 6 ones -> count 1,2,3,3; Count_sat=1 from the third match; Clear_count alongside a match -> count=1.
- Reset pulse after bits 1,0 of 101, then stream 1 -> no match. Load asserted mid-window -> no match until PAT_W new valid bits; count preserved.
